// File: rtl/mac_rx.sv
// Ethernet receive MAC: preamble/SFD strip, header capture, address filter, CRC-32 and length check, frame counters.
// Payload byte k leaves one cycle after byte k+4 is sampled (FCS withheld); there is no backpressure, the PHY stream is never stalled.
module mac_rx #(
    parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01,
    parameter int          MAX_FRAME = 1518
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  mac_rxd,
    input  logic        mac_rx_dv,
    input  logic        mac_rx_er,
    input  logic        promisc,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        rx_hdr_valid,
    output logic [47:0] rx_dest_mac,
    output logic [47:0] rx_src_mac,
    output logic [15:0] rx_frame_type,
    output logic        rx_eof,
    output logic        rx_good,
    output logic        rx_crc_err,
    output logic        rx_len_err,
    output logic [15:0] rx_frame_cnt,
    output logic [15:0] rx_err_cnt
);

    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [15:0] LEN_MIN     = 16'd64;
    localparam logic [15:0] LEN_MAX     = 16'(MAX_FRAME);
    localparam logic [15:0] LEN_ABORT   = 16'(MAX_FRAME + 1);

    typedef enum logic [2:0] {
        IDLE, PREAMBLE, DEST_MAC, SRC_MAC, FRAME_TYPE, PAYLOAD, DROP
    } state_t;

    typedef struct packed {
        logic [47:0] dest;
        logic [47:0] src;
        logic [15:0] ftype;
    } hdr_t;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    state_t          state_q, state_d;
    logic            dv_prev_q;
    logic [2:0]      byte_cnt_q, byte_cnt_d;
    logic [2:0]      pay_cnt_q, pay_cnt_d;
    logic [15:0]     len_q, len_d;
    logic [31:0]     crc_q, crc_d;
    logic            er_seen_q, er_seen_d;
    logic [47:0]     dest_sh_q, dest_sh_d;
    logic [47:0]     src_sh_q, src_sh_d;
    logic [7:0]      type_hi_q, type_hi_d;
    logic [3:0][7:0] dly_q, dly_d;
    hdr_t            hdr_q, hdr_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            rx_sof_q, rx_sof_d;
    logic            rx_hdr_valid_q, rx_hdr_valid_d;
    logic            rx_eof_q, rx_eof_d;
    logic            rx_good_q, rx_good_d;
    logic            rx_crc_err_q, rx_crc_err_d;
    logic            rx_len_err_q, rx_len_err_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic [15:0]     err_cnt_q, err_cnt_d;

    logic            dv_rise;
    logic [47:0]     dest_full;
    logic            addr_pass;
    logic [31:0]     crc_next;
    logic [15:0]     len_inc;
    logic            end_len_err;

    assign dv_rise     = mac_rx_dv & ~dv_prev_q;
    assign dest_full   = {dest_sh_q[39:0], mac_rxd};
    assign addr_pass   = promisc || (dest_full == LOCAL_MAC) || (dest_full == 48'hFFFF_FFFF_FFFF);
    assign crc_next    = crc_byte(crc_q, mac_rxd);
    assign len_inc     = len_q + 16'd1;
    assign end_len_err = (len_q < LEN_MIN) || (len_q > LEN_MAX);

    always_comb begin
        state_d        = state_q;
        byte_cnt_d     = byte_cnt_q;
        pay_cnt_d      = pay_cnt_q;
        len_d          = len_q;
        crc_d          = crc_q;
        er_seen_d      = er_seen_q;
        dest_sh_d      = dest_sh_q;
        src_sh_d       = src_sh_q;
        type_hi_d      = type_hi_q;
        dly_d          = dly_q;
        hdr_d          = hdr_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rx_sof_d       = 1'b0;
        rx_hdr_valid_d = 1'b0;
        rx_eof_d       = 1'b0;
        rx_good_d      = 1'b0;
        rx_crc_err_d   = 1'b0;
        rx_len_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // Only a fresh dv assertion starts a frame; dv already high after reset is ignored.
                if (dv_rise) begin
                    er_seen_d = mac_rx_er;
                    state_d   = (mac_rxd == 8'h55) ? PREAMBLE : DROP;
                end
            end
            PREAMBLE: begin
                if (!mac_rx_dv) begin
                    state_d = IDLE;
                end else begin
                    er_seen_d = er_seen_q | mac_rx_er;
                    if (mac_rxd == 8'hD5) begin
                        state_d    = DEST_MAC;
                        crc_d      = CRC_INIT;
                        len_d      = 16'd0;
                        byte_cnt_d = 3'd0;
                    end else if (mac_rxd != 8'h55) begin
                        state_d = DROP;
                    end
                end
            end
            DEST_MAC, SRC_MAC, FRAME_TYPE: begin
                if (!mac_rx_dv) begin
                    state_d = IDLE;
                end else begin
                    er_seen_d  = er_seen_q | mac_rx_er;
                    crc_d      = crc_next;
                    len_d      = len_inc;
                    byte_cnt_d = byte_cnt_q + 3'd1;
                    if (state_q == DEST_MAC) begin
                        dest_sh_d = dest_full;
                        if (byte_cnt_q == 3'd5) begin
                            byte_cnt_d = 3'd0;
                            state_d    = addr_pass ? SRC_MAC : DROP;
                        end
                    end else if (state_q == SRC_MAC) begin
                        src_sh_d = {src_sh_q[39:0], mac_rxd};
                        if (byte_cnt_q == 3'd5) begin
                            byte_cnt_d = 3'd0;
                            state_d    = FRAME_TYPE;
                        end
                    end else begin
                        type_hi_d = mac_rxd;
                        if (byte_cnt_q == 3'd1) begin
                            byte_cnt_d     = 3'd0;
                            pay_cnt_d      = 3'd0;
                            rx_hdr_valid_d = 1'b1;
                            hdr_d.dest     = dest_sh_q;
                            hdr_d.src      = src_sh_q;
                            hdr_d.ftype    = {type_hi_q, mac_rxd};
                            state_d        = PAYLOAD;
                        end
                    end
                end
            end
            PAYLOAD: begin
                if (mac_rx_dv) begin
                    er_seen_d = er_seen_q | mac_rx_er;
                    crc_d     = crc_next;
                    len_d     = len_inc;
                    dly_d     = {dly_q[2:0], mac_rxd};
                    if (len_inc == LEN_ABORT) begin
                        // Oversize: close the frame now and discard whatever follows.
                        rx_eof_d     = 1'b1;
                        rx_len_err_d = 1'b1;
                        rx_crc_err_d = (crc_next != CRC_RESIDUE);
                        state_d      = DROP;
                    end else if (pay_cnt_q >= 3'd4) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = dly_q[3];
                        rx_sof_d   = (pay_cnt_q == 3'd4);
                    end
                    if (pay_cnt_q != 3'd5) begin
                        pay_cnt_d = pay_cnt_q + 3'd1;
                    end
                end else begin
                    rx_eof_d     = 1'b1;
                    rx_crc_err_d = (crc_q != CRC_RESIDUE);
                    rx_len_err_d = end_len_err;
                    rx_good_d    = (crc_q == CRC_RESIDUE) && !end_len_err && !er_seen_q;
                    state_d      = IDLE;
                end
            end
            DROP: begin
                if (!mac_rx_dv) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (rx_eof_d) begin
            if (rx_good_d) begin
                frame_cnt_d = (frame_cnt_q == 16'hFFFF) ? frame_cnt_q : frame_cnt_q + 16'd1;
            end else begin
                err_cnt_d = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            dv_prev_q      <= 1'b1;
            byte_cnt_q     <= 3'd0;
            pay_cnt_q      <= 3'd0;
            len_q          <= 16'd0;
            crc_q          <= CRC_INIT;
            er_seen_q      <= 1'b0;
            dest_sh_q      <= 48'd0;
            src_sh_q       <= 48'd0;
            type_hi_q      <= 8'd0;
            dly_q          <= '0;
            hdr_q          <= '0;
            rx_data_q      <= 8'd0;
            rx_valid_q     <= 1'b0;
            rx_sof_q       <= 1'b0;
            rx_hdr_valid_q <= 1'b0;
            rx_eof_q       <= 1'b0;
            rx_good_q      <= 1'b0;
            rx_crc_err_q   <= 1'b0;
            rx_len_err_q   <= 1'b0;
            frame_cnt_q    <= 16'd0;
            err_cnt_q      <= 16'd0;
        end else begin
            state_q        <= state_d;
            dv_prev_q      <= mac_rx_dv;
            byte_cnt_q     <= byte_cnt_d;
            pay_cnt_q      <= pay_cnt_d;
            len_q          <= len_d;
            crc_q          <= crc_d;
            er_seen_q      <= er_seen_d;
            dest_sh_q      <= dest_sh_d;
            src_sh_q       <= src_sh_d;
            type_hi_q      <= type_hi_d;
            dly_q          <= dly_d;
            hdr_q          <= hdr_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rx_sof_q       <= rx_sof_d;
            rx_hdr_valid_q <= rx_hdr_valid_d;
            rx_eof_q       <= rx_eof_d;
            rx_good_q      <= rx_good_d;
            rx_crc_err_q   <= rx_crc_err_d;
            rx_len_err_q   <= rx_len_err_d;
            frame_cnt_q    <= frame_cnt_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_sof        = rx_sof_q;
    assign rx_hdr_valid  = rx_hdr_valid_q;
    assign rx_dest_mac   = hdr_q.dest;
    assign rx_src_mac    = hdr_q.src;
    assign rx_frame_type = hdr_q.ftype;
    assign rx_eof        = rx_eof_q;
    assign rx_good       = rx_good_q;
    assign rx_crc_err    = rx_crc_err_q;
    assign rx_len_err    = rx_len_err_q;
    assign rx_frame_cnt  = frame_cnt_q;
    assign rx_err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_mac_rx.sv
// Scoreboard bench for mac_rx: stimulus queues expected header/payload/status, a negedge monitor pops and compares.
module tb_mac_rx;

    localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BCAST     = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] SRC_MAC   = 48'h0A0B_0C0D_0E0F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  mac_rxd = 8'd0;
    logic        mac_rx_dv = 1'b0;
    logic        mac_rx_er = 1'b0;
    logic        promisc = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_sof, rx_hdr_valid, rx_eof;
    logic [47:0] rx_dest_mac, rx_src_mac;
    logic [15:0] rx_frame_type;
    logic        rx_good, rx_crc_err, rx_len_err;
    logic [15:0] rx_frame_cnt, rx_err_cnt;

    mac_rx #(.LOCAL_MAC(LOCAL_MAC), .MAX_FRAME(1518)) dut (
        .clk(clk), .rst(rst), .mac_rxd(mac_rxd), .mac_rx_dv(mac_rx_dv), .mac_rx_er(mac_rx_er),
        .promisc(promisc), .rx_data(rx_data), .rx_valid(rx_valid), .rx_sof(rx_sof),
        .rx_hdr_valid(rx_hdr_valid), .rx_dest_mac(rx_dest_mac), .rx_src_mac(rx_src_mac),
        .rx_frame_type(rx_frame_type), .rx_eof(rx_eof), .rx_good(rx_good), .rx_crc_err(rx_crc_err),
        .rx_len_err(rx_len_err), .rx_frame_cnt(rx_frame_cnt), .rx_err_cnt(rx_err_cnt)
    );

    always #4 clk = ~clk;

    typedef struct packed {
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] typ;
    } exp_hdr_t;

    typedef struct packed {
        logic good;
        logic crc_err;
        logic len_err;
        logic crc_dc;
    } exp_eof_t;

    exp_hdr_t   hdr_q[$];
    exp_eof_t   eof_q[$];
    logic [8:0] byte_q[$];
    logic [7:0] frm[$];
    logic [7:0] wire_q[$];

    int nchecks = 0;
    int nerrors = 0;
    int exp_good = 0;
    int exp_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        nchecks++;
        nerrors++;
        $display("FAIL %s: got output %0h, expected none", name, act);
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB8_8320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    task automatic build(input logic [47:0] dst, input logic [15:0] typ, input int plen,
                         input logic [7:0] seed, input bit flip);
        logic [31:0] c;
        frm.delete();
        for (int i = 5; i >= 0; i--) frm.push_back(dst[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) frm.push_back(SRC_MAC[i*8 +: 8]);
        frm.push_back(typ[15:8]);
        frm.push_back(typ[7:0]);
        for (int i = 0; i < plen; i++) frm.push_back(seed + 8'(i));
        c = 32'hFFFF_FFFF;
        foreach (frm[i]) c = crc_upd(c, frm[i]);
        c = ~c;
        for (int i = 0; i < 4; i++) frm.push_back(c[i*8 +: 8]);
        if (flip) frm[frm.size() - 2] = frm[frm.size() - 2] ^ 8'h04;
        wire_q.delete();
        repeat (7) wire_q.push_back(8'h55);
        wire_q.push_back(8'hD5);
        foreach (frm[i]) wire_q.push_back(frm[i]);
    endtask

    task automatic exp_hdr();
        exp_hdr_t h;
        h = '0;
        for (int i = 0; i < 6; i++) h.dst = {h.dst[39:0], frm[i]};
        for (int i = 6; i < 12; i++) h.src = {h.src[39:0], frm[i]};
        h.typ = {frm[12], frm[13]};
        hdr_q.push_back(h);
    endtask

    task automatic exp_payload(input int n);
        for (int i = 0; i < n; i++) byte_q.push_back({i == 0, frm[14 + i]});
    endtask

    task automatic exp_eof(input bit good, input bit crc_err, input bit len_err, input bit crc_dc);
        exp_eof_t e;
        e.good = good; e.crc_err = crc_err; e.len_err = len_err; e.crc_dc = crc_dc;
        eof_q.push_back(e);
        if (good) exp_good++;
        else      exp_err++;
    endtask

    task automatic full_frame(input bit good, input bit crc_err, input bit len_err);
        exp_hdr();
        exp_payload(frm.size() - 18);
        exp_eof(good, crc_err, len_err, 1'b0);
    endtask

    // stop_at / er_at / rst_at are wire_q indices; -1 disables.
    task automatic send(input int stop_at, input int er_at, input int rst_at);
        for (int i = 0; i < wire_q.size(); i++) begin
            if (i == stop_at) break;
            @(posedge clk); #1;
            mac_rxd = wire_q[i]; mac_rx_dv = 1'b1; mac_rx_er = (i == er_at); rst = (i == rst_at);
        end
        @(posedge clk); #1;
        mac_rx_dv = 1'b0; mac_rx_er = 1'b0; mac_rxd = 8'd0; rst = 1'b0;
        repeat (12) @(posedge clk);
    endtask

    task automatic check_cnt(input string tag);
        @(negedge clk);
        chk({tag, "_frame_cnt"}, 64'(rx_frame_cnt), 64'(exp_good));
        chk({tag, "_err_cnt"}, 64'(rx_err_cnt), 64'(exp_err));
    endtask

    always @(negedge clk) begin
        logic [8:0] eb;
        exp_hdr_t   eh;
        exp_eof_t   ee;
        if (rx_valid) begin
            if (byte_q.size() == 0) unexpected("rx_valid", 64'(rx_data));
            else begin
                eb = byte_q.pop_front();
                chk("rx_data", 64'(rx_data), 64'(eb[7:0]));
                chk("rx_sof", 64'(rx_sof), 64'(eb[8]));
            end
        end else if (rx_sof) unexpected("rx_sof_without_valid", 64'(rx_sof));
        if (rx_hdr_valid) begin
            if (hdr_q.size() == 0) unexpected("rx_hdr_valid", 64'(rx_dest_mac));
            else begin
                eh = hdr_q.pop_front();
                chk("rx_dest_mac", 64'(rx_dest_mac), 64'(eh.dst));
                chk("rx_src_mac", 64'(rx_src_mac), 64'(eh.src));
                chk("rx_frame_type", 64'(rx_frame_type), 64'(eh.typ));
            end
        end
        if (rx_eof) begin
            chk("valid_with_eof", 64'(rx_valid), 64'(0));
            if (eof_q.size() == 0) unexpected("rx_eof", 64'({rx_good, rx_crc_err, rx_len_err}));
            else begin
                ee = eof_q.pop_front();
                chk("rx_good", 64'(rx_good), 64'(ee.good));
                chk("rx_len_err", 64'(rx_len_err), 64'(ee.len_err));
                if (!ee.crc_dc) chk("rx_crc_err", 64'(rx_crc_err), 64'(ee.crc_err));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at time limit, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_rx_valid", 64'(rx_valid), 64'(0));
        chk("reset_rx_eof", 64'(rx_eof), 64'(0));
        chk("reset_rx_hdr_valid", 64'(rx_hdr_valid), 64'(0));
        chk("reset_rx_dest_mac", 64'(rx_dest_mac), 64'(0));
        chk("reset_rx_good", 64'(rx_good), 64'(0));
        check_cnt("reset");
        repeat (4) @(posedge clk);

        // Good minimum-size frame (L=64).
        build(LOCAL_MAC, 16'h0800, 46, 8'h30, 1'b0);
        full_frame(1'b1, 1'b0, 1'b0);
        send(-1, -1, -1);
        check_cnt("good");

        // Corrupted FCS.
        build(LOCAL_MAC, 16'h0800, 46, 8'h30, 1'b1);
        full_frame(1'b0, 1'b1, 1'b0);
        send(-1, -1, -1);
        check_cnt("badfcs");

        // Foreign destination: filtered, then accepted in promiscuous mode.
        build(48'h1122_3344_5566, 16'h0806, 46, 8'h80, 1'b0);
        send(-1, -1, -1);
        check_cnt("filtered");
        promisc = 1'b1;
        full_frame(1'b1, 1'b0, 1'b0);
        send(-1, -1, -1);
        check_cnt("promisc");
        promisc = 1'b0;

        // Runt broadcast (L=38).
        build(BCAST, 16'h0800, 20, 8'hA0, 1'b0);
        full_frame(1'b0, 1'b0, 1'b1);
        send(-1, -1, -1);
        check_cnt("runt");

        // PHY error on payload byte 3.
        build(LOCAL_MAC, 16'h86DD, 46, 8'h10, 1'b0);
        full_frame(1'b0, 1'b0, 1'b0);
        send(-1, 8 + 14 + 3, -1);
        check_cnt("phy_err");

        // dv drops inside the source address, then a bad preamble byte, then a bad first byte.
        build(LOCAL_MAC, 16'h0800, 46, 8'h30, 1'b0);
        send(8 + 9, -1, -1);
        wire_q[3] = 8'h5A;
        send(-1, -1, -1);
        wire_q[3] = 8'h55;
        wire_q[0] = 8'hD5;
        send(-1, -1, -1);
        check_cnt("aborted");

        // Maximum-size good frame (L=1518).
        build(LOCAL_MAC, 16'h0800, 1500, 8'h00, 1'b0);
        full_frame(1'b1, 1'b0, 1'b0);
        send(-1, -1, -1);
        check_cnt("max_frame");

        // Oversize 1600-byte frame: cut at L=1519 after 1500 payload bytes.
        build(LOCAL_MAC, 16'h0800, 1582, 8'h40, 1'b0);
        exp_hdr();
        exp_payload(1500);
        exp_eof(1'b0, 1'b0, 1'b1, 1'b1);
        send(-1, -1, -1);
        check_cnt("oversize");
        build(BCAST, 16'h0800, 60, 8'h55, 1'b0);
        full_frame(1'b1, 1'b0, 1'b0);
        send(-1, -1, -1);
        check_cnt("after_oversize");

        // Reset at payload byte 10 with dv held high; bytes 0..5 were already out.
        build(LOCAL_MAC, 16'h0800, 46, 8'h30, 1'b0);
        exp_hdr();
        exp_payload(6);
        send(-1, -1, 8 + 14 + 10);
        exp_good = 0;
        exp_err = 0;
        check_cnt("mid_reset");
        build(LOCAL_MAC, 16'h0801, 50, 8'h61, 1'b0);
        full_frame(1'b1, 1'b0, 1'b0);
        send(-1, -1, -1);
        check_cnt("after_reset");

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("pending_bytes", 64'(byte_q.size()), 64'(0));
        chk("pending_hdrs", 64'(hdr_q.size()), 64'(0));
        chk("pending_eofs", 64'(eof_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
